ro_scan_controller: RTL and testbench
=====================================

RO_SCAN_CONTROLLER -- requirements
Module: ro_scan_controller

Interface
REQ-001 Parameter N_OSC, default 10: number of ring oscillators in the matrix.
REQ-002 Parameter RESOL, default 1000: measurement window length in clock cycles (≥1).
REQ-003 Parameter SETTLE, default 4: oscillator start-up wait in clock cycles (≥2).
REQ-004 Parameter WIDTH, default 32: edge-count width.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  scan request; sampled only in IDLE.
REQ-008 ro_signal  in  1  selected oscillator output from the matrix interface; asynchronous to clock, frequency < clock/2.
REQ-009 enable_ro  out  1  enable to the matrix interface.
REQ-010 sel_ro  out  $clog2(N_OSC)  oscillator select to the matrix interface.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse at scan completion.
REQ-013 count_data  out  WIDTH  edge count of oscillator count_index.
REQ-014 count_index  out  $clog2(N_OSC)  oscillator index of count_data.
REQ-015 count_valid  out  1  result available.
REQ-016 count_ready  in  1  consumer accepts result.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, MEASURE, EMIT.
REQ-018 IDLE with start=1 SHALL enter SETTLE next cycle with sel_ro=0; start while busy SHALL be ignored.
REQ-019 SETTLE SHALL last exactly SETTLE cycles, then MEASURE; edge counter SHALL be cleared on SETTLE entry.
REQ-020 MEASURE SHALL last exactly RESOL cycles, then EMIT.
REQ-021 ro_signal SHALL pass a 2-flop synchronizer plus one history flop; rising edge detected when sync2=1 and history=0.
REQ-022 Counter SHALL increment by 1 for each MEASURE cycle with edge detect true; edges detected outside MEASURE SHALL be ignored.
REQ-023 Counter SHALL saturate at 2^WIDTH-1, no wrap.
REQ-024 enable_ro SHALL be 1 in SETTLE and MEASURE, 0 in IDLE and EMIT.
REQ-025 sel_ro SHALL be constant from SETTLE entry until EMIT exit.
REQ-026 In EMIT count_valid SHALL be 1, count_data and count_index (= sel_ro) stable until transfer (count_valid & count_ready).
REQ-027 count_valid SHALL not be asserted outside EMIT; count_ready outside EMIT SHALL be ignored.
REQ-028 On transfer with sel_ro < N_OSC-1: sel_ro increments, next state SETTLE.
REQ-029 On transfer with sel_ro = N_OSC-1: next state IDLE, done=1 for that next cycle only, sel_ro returns to 0.
REQ-030 Latency: start accepted at cycle t gives first count_valid at t+1+SETTLE+RESOL; with count_ready held 1, each oscillator occupies SETTLE+RESOL+1 cycles.

Reset
REQ-031 reset=1 SHALL, at the next edge, force IDLE from any state, including mid-MEASURE or stalled EMIT.
REQ-032 Reset values: enable_ro=0, sel_ro=0, busy=0, done=0, count_valid=0, count_data=0, count_index=0, synchronizer and history flops=0.
REQ-033 start asserted together with reset SHALL be ignored.

Verification
REQ-034 N_OSC=4, RESOL=1000, SETTLE=4, ro_signal square wave period 10 clocks, count_ready=1, start pulse at t=0 -> four results indices 0..3, count_data=100 each, first count_valid at t=1005, done one cycle after 4th transfer.
REQ-035 count_ready=0 for 50 cycles in first EMIT -> count_valid, count_data, count_index, sel_ro held; enable_ro=0; no extra edges counted.
REQ-036 WIDTH=4, ro_signal period 4, RESOL=200 -> count_data=15 (saturated).
REQ-037 reset pulse mid-MEASURE of oscillator 2 -> next cycle IDLE, enable_ro=0, busy=0, count_valid=0; new start restarts at sel_ro=0.
REQ-038 start pulses during busy and with reset -> ignored; ro_signal toggling in IDLE -> count after next scan unaffected.

Source files
------------

// File: rtl/ro_scan_controller_if.sv
// rtl/ro_scan_controller_if.sv - result handshake between ro_scan_controller and its consumer
interface ro_scan_controller_if #(
    parameter int IDX_W = 4,
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] count_data;
    logic [IDX_W-1:0] count_index;
    logic             count_valid;
    logic             count_ready;

    modport master (
        output count_data,
        output count_index,
        output count_valid,
        input  count_ready
    );

    modport slave (
        input  count_data,
        input  count_index,
        input  count_valid,
        output count_ready
    );
endinterface

// File: rtl/ro_scan_controller.sv
// rtl/ro_scan_controller.sv - sequential ring-oscillator scan: settle, count edges, emit per oscillator
module ro_scan_controller #(
    parameter int N_OSC  = 10,
    parameter int RESOL  = 1000,
    parameter int SETTLE = 4,
    parameter int WIDTH  = 32,
    localparam int IDX_W = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             ro_signal,
    output logic             enable_ro,
    output logic [IDX_W-1:0] sel_ro,
    output logic             busy,
    output logic             done,
    ro_scan_controller_if.master result
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_EMIT    = 2'd3;

    // Timer must hold the longer of the two phase lengths.
    localparam int TMAX  = (RESOL > SETTLE) ? RESOL : SETTLE;
    localparam int TMR_W = $clog2(TMAX) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] RESOL_LAST  = TMR_W'(RESOL - 1);
    localparam logic [IDX_W-1:0] LAST_SEL    = IDX_W'(N_OSC - 1);

    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic [WIDTH-1:0] edge_count;
    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             rise;
    logic             transfer;
    logic             next_osc;

    assign rise      = sync2 & ~hist;
    assign transfer  = (state == ST_EMIT) && result.count_ready;
    // A new oscillator begins either from IDLE or after a non-final transfer.
    assign next_osc  = ((state == ST_IDLE) && start) || (transfer && (sel_ro != LAST_SEL));

    assign enable_ro          = (state == ST_SETTLE) || (state == ST_MEASURE);
    assign busy               = (state != ST_IDLE);
    assign result.count_valid = (state == ST_EMIT);
    assign result.count_data  = edge_count;
    assign result.count_index = sel_ro;

    // Two-flop synchronizer for the asynchronous oscillator output plus one history flop
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= ro_signal;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Scan sequencer: phase timing, oscillator select and completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            timer  <= '0;
            sel_ro <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SETTLE;
                        sel_ro <= '0;
                        timer  <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        state <= ST_MEASURE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (timer == RESOL_LAST) begin
                        state <= ST_EMIT;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (transfer) begin
                        timer <= '0;
                        if (sel_ro == LAST_SEL) begin
                            state  <= ST_IDLE;
                            sel_ro <= '0;
                            done   <= 1'b1;
                        end else begin
                            state  <= ST_SETTLE;
                            sel_ro <= sel_ro + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Edge counter: cleared as each oscillator enters SETTLE, saturating count during MEASURE only
    always_ff @(posedge clock) begin
        if (reset) begin
            edge_count <= '0;
        end else if (next_osc) begin
            edge_count <= '0;
        end else if ((state == ST_MEASURE) && rise && (edge_count != {WIDTH{1'b1}})) begin
            edge_count <= edge_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ro_scan_controller.sv
// tb/tb_ro_scan_controller.sv - randomized self-checking bench for ro_scan_controller
module tb_ro_scan_controller;
    localparam int N = 4;
    localparam int R = 1000;
    localparam int S = 4;
    localparam int W = 32;
    localparam int LOG_LEN = 65536;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ro_signal = 1'b0;
    logic       enable_ro;
    logic       busy;
    logic       done;
    logic [1:0] sel_ro;
    ro_scan_controller_if #(.IDX_W(2), .WIDTH(W)) res ();

    logic       start2 = 1'b0;
    logic       ro2 = 1'b0;
    logic       enable2;
    logic       busy2;
    logic       done2;
    logic [0:0] sel2;
    ro_scan_controller_if #(.IDX_W(1), .WIDTH(4)) res2 ();

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit vlog [LOG_LEN];
    int per = 10;
    int hi = 5;
    int ph = 0;
    logic [1:0] ph2 = 2'd0;

    ro_scan_controller #(.N_OSC(N), .RESOL(R), .SETTLE(S), .WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .ro_signal(ro_signal),
        .enable_ro(enable_ro), .sel_ro(sel_ro), .busy(busy), .done(done), .result(res)
    );

    ro_scan_controller #(.N_OSC(2), .RESOL(200), .SETTLE(2), .WIDTH(4)) dut_sat (
        .clock(clock), .reset(reset), .start(start2), .ro_signal(ro2),
        .enable_ro(enable2), .sel_ro(sel2), .busy(busy2), .done(done2), .result(res2)
    );

    always #5 clock = ~clock;

    // Oscillator models: programmable period/duty for the main DUT, fixed period 4 for the saturation DUT
    always @(negedge clock) begin
        ro_signal <= (ph < hi);
        ph        <= (ph + 1 >= per) ? 0 : ph + 1;
        ro2       <= ph2[1];
        ph2       <= ph2 + 2'd1;
    end

    // Cycle counter and log of the oscillator value seen at each rising edge
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cyc + 1 < LOG_LEN) vlog[cyc + 1] <= ro_signal;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A value sampled high at edge n-1 after low at edge n-2 is seen as a rising edge during cycle n.
    function automatic int edges_in(input int a, input int b);
        int c;
        c = 0;
        for (int n = a; n <= b; n++) if (vlog[n - 1] && !vlog[n - 2]) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic busy_wait(input bit rnd);
        if (rnd) begin
            res.count_ready = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 63) == 0);
        end else begin
            res.count_ready = 1'b1;
            start = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic run_scan(input int first_stall, input bit rnd, input int fixed_exp, input int abort_osc);
        int p;
        int d;
        int exp_cnt;
        @(negedge clock);
        start = 1'b1;
        p = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_sel", sel_ro, 0);
        for (int i = 0; i < N; i++) begin
            if (i == abort_osc) begin
                while (cyc < p + S + 10) busy_wait(rnd);
                check("abort_pre_enable", enable_ro, 1);
                reset = 1'b1;
                start = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                start = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_enable", enable_ro, 0);
                check("abort_valid", res.count_valid, 0);
                check("abort_sel", sel_ro, 0);
                check("abort_data", res.count_data, 0);
                return;
            end
            while (cyc < p + S + R - 1) busy_wait(rnd);
            check("measure_valid", res.count_valid, 0);
            check("measure_enable", enable_ro, 1);
            check("measure_sel", sel_ro, i);
            d = (i == 0) ? first_stall : (rnd ? int'($urandom_range(0, 3)) : 0);
            @(negedge clock);
            exp_cnt = (fixed_exp >= 0) ? fixed_exp : edges_in(p + S, p + S + R - 1);
            check("emit_valid", res.count_valid, 1);
            check("emit_index", res.count_index, i);
            check("emit_data", res.count_data, exp_cnt);
            check("emit_enable", enable_ro, 0);
            for (int k = 0; k < d; k++) begin
                res.count_ready = 1'b0;
                start = rnd && ($urandom_range(0, 7) == 0);
                @(negedge clock);
                check("stall_valid", res.count_valid, 1);
                check("stall_data", res.count_data, exp_cnt);
                check("stall_index", res.count_index, i);
                check("stall_sel", sel_ro, i);
                check("stall_enable", enable_ro, 0);
            end
            res.count_ready = 1'b1;
            start = 1'b0;
            p = cyc + 1;
            @(negedge clock);
            res.count_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i < N - 1) begin
                check("next_valid", res.count_valid, 0);
                check("next_sel", sel_ro, i + 1);
                check("next_enable", enable_ro, 1);
            end else begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                check("done_sel", sel_ro, 0);
                check("done_valid", res.count_valid, 0);
                @(negedge clock);
                check("done_single", done, 0);
            end
        end
    endtask

    initial begin
        int p;
        res.count_ready = 1'b0;
        res2.count_ready = 1'b1;
        reset = 1'b1;
        start = 1'b1;
        start2 = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_enable", enable_ro, 0);
        check("rst_sel", sel_ro, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", res.count_valid, 0);
        check("rst_data", res.count_data, 0);
        check("rst_index", res.count_index, 0);
        check("rst_busy2", busy2, 0);
        reset = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        @(negedge clock);
        check("start_with_reset_ignored", busy, 0);

        // Saturation: 50 edges in a 200-cycle window into a 4-bit counter
        start2 = 1'b1;
        p = cyc + 1;
        @(negedge clock);
        start2 = 1'b0;
        while (cyc < p + 2 + 200) @(negedge clock);
        check("sat_valid0", res2.count_valid, 1);
        check("sat_data0", res2.count_data, 15);
        check("sat_index0", res2.count_index, 0);
        p = p + 203;
        while (cyc < p + 2 + 200) @(negedge clock);
        check("sat_data1", res2.count_data, 15);
        check("sat_index1", res2.count_index, 1);
        @(negedge clock);
        check("sat_done", done2, 1);
        check("sat_idle", busy2, 0);

        // Directed: period 10 over a 1000-cycle window gives exactly 100 edges
        per = 10;
        hi = 5;
        run_scan(0, 1'b0, 100, -1);

        // Randomized scans, first with a 50-cycle consumer stall
        for (int s = 0; s < 3; s++) begin
            per = $urandom_range(3, 15);
            hi = $urandom_range(1, per - 1);
            repeat ($urandom_range(2, 20)) begin
                start = 1'b0;
                res.count_ready = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            check("idle_valid", res.count_valid, 0);
            check("idle_enable", enable_ro, 0);
            run_scan((s == 0) ? 50 : 0, 1'b1, -1, -1);
        end

        // Reset in the middle of oscillator 2 measurement, then a clean restart
        per = $urandom_range(3, 15);
        hi = $urandom_range(1, per - 1);
        run_scan(0, 1'b1, -1, 2);
        repeat (5) @(negedge clock);
        check("post_abort_idle", busy, 0);
        per = $urandom_range(3, 15);
        hi = $urandom_range(1, per - 1);
        run_scan(0, 1'b1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
